// File: rtl/onetofourdemux6bit.sv
// ---------------------------------------------------------------------------
// onetofourdemux6bit
//   Registered 1-to-4 demultiplexer for WIDTH-bit data. One word per cycle is
//   accepted on a valid/ready input and steered into one of four single-word
//   channel holding registers. Each channel has its own valid/ready handshake
//   toward its consumer. Steering is either manual (DemuxOpt) or round-robin
//   (autoMode, pointer rrPtr).
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   demuxIn       input data word
//   demuxInValid  input word present
//   demuxInReady  block can take the word this cycle (combinational)
//   DemuxOpt      manual target: 0->ch1, 1->ch2, 2->ch3, 3->ch4
//   autoMode      1 = steer by rrPtr, 0 = steer by DemuxOpt
//   demuxOut1..4  channel holding registers
//   outValid      bit n-1 set = channel n holds an undelivered word
//   outReady      bit n-1 set = channel n consumer takes its word this cycle
//   rrPtr         next round-robin target
//   wordCount     accepted words, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module onetofourdemux6bit #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] demuxIn,
    input  logic             demuxInValid,
    output logic             demuxInReady,
    input  logic [1:0]       DemuxOpt,
    input  logic             autoMode,
    output logic [WIDTH-1:0] demuxOut1,
    output logic [WIDTH-1:0] demuxOut2,
    output logic [WIDTH-1:0] demuxOut3,
    output logic [WIDTH-1:0] demuxOut4,
    output logic [3:0]       outValid,
    input  logic [3:0]       outReady,
    output logic [1:0]       rrPtr,
    output logic [CNT_W-1:0] wordCount
);

    // Modulo increments: both counters wrap naturally at their width.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + 1'b1;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'd1;
    endfunction

    logic [1:0]       target;
    logic             accept;
    logic [3:0]       load_sel;
    logic [WIDTH-1:0] chan_p1 [4];
    logic [3:0]       vld_p1;
    logic [1:0]       rr_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Input stage: target selection and handshake. Ready looks only at the
    // target channel, so a full channel that drains this cycle can be
    // refilled in the same cycle, and round-robin never skips a busy channel.
    always_comb begin
        target       = autoMode ? rr_p1 : DemuxOpt;
        demuxInReady = ~vld_p1[target] | outReady[target];
        accept       = demuxInValid & demuxInReady;
        load_sel     = accept ? (4'b0001 << target) : 4'b0000;
    end

    // Channel register stage: a reload takes priority over a drain on the
    // same channel, so a word is never lost when both happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                chan_p1[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (load_sel[n]) begin
                    chan_p1[n] <= demuxIn;
                    vld_p1[n]  <= 1'b1;
                end else if (outReady[n]) begin
                    vld_p1[n]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_p1  <= 2'd0;
            cnt_p1 <= '0;
        end else if (accept) begin
            cnt_p1 <= cnt_inc(cnt_p1);
            // Pointer only advances on auto-mode accepts; it is kept across
            // manual periods so round-robin resumes where it left off.
            if (autoMode) begin
                rr_p1 <= ptr_inc(rr_p1);
            end
        end
    end

    assign demuxOut1 = chan_p1[0];
    assign demuxOut2 = chan_p1[1];
    assign demuxOut3 = chan_p1[2];
    assign demuxOut4 = chan_p1[3];
    assign outValid  = vld_p1;
    assign rrPtr     = rr_p1;
    assign wordCount = cnt_p1;

endmodule

// File: tb/tb_onetofourdemux6bit.sv
// ---------------------------------------------------------------------------
// tb_onetofourdemux6bit
//   Self-checking bench for onetofourdemux6bit. Words are pushed to a
//   scoreboard with their expected channel when accepted and popped and
//   compared one cycle later when the channel register shows them.
// ---------------------------------------------------------------------------
module tb_onetofourdemux6bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] demuxIn;
    logic       demuxInValid;
    logic       demuxInReady;
    logic [1:0] DemuxOpt;
    logic       autoMode;
    logic [5:0] demuxOut1, demuxOut2, demuxOut3, demuxOut4;
    logic [3:0] outValid;
    logic [3:0] outReady;
    logic [1:0] rrPtr;
    logic [7:0] wordCount;

    onetofourdemux6bit #(.WIDTH(6), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .demuxIn      (demuxIn),
        .demuxInValid (demuxInValid),
        .demuxInReady (demuxInReady),
        .DemuxOpt     (DemuxOpt),
        .autoMode     (autoMode),
        .demuxOut1    (demuxOut1),
        .demuxOut2    (demuxOut2),
        .demuxOut3    (demuxOut3),
        .demuxOut4    (demuxOut4),
        .outValid     (outValid),
        .outReady     (outReady),
        .rrPtr        (rrPtr),
        .wordCount    (wordCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [5:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_rr;
    logic [7:0] m_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [5:0] get_out(input logic [1:0] ch);
        case (ch)
            2'd0:    return demuxOut1;
            2'd1:    return demuxOut2;
            2'd2:    return demuxOut3;
            default: return demuxOut4;
        endcase
    endfunction

    // Drives one word, waits (bounded) for acceptance, records the expected
    // channel, and returns at 1 time unit after the accepting edge.
    task automatic send(input logic [5:0] d, input logic [1:0] opt,
                        input logic am, output bit ok);
        int waited = 0;
        logic [1:0] tgt;
        demuxIn = d; DemuxOpt = opt; autoMode = am; demuxInValid = 1'b1;
        #1;
        while (demuxInReady !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (demuxInReady !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout word=%h ready=%b required=1", d, demuxInReady);
            demuxInValid = 1'b0;
            ok = 1'b0;
            return;
        end
        tgt = am ? m_rr : opt;
        sb.push_back('{ch: tgt, d: d});
        @(posedge clk); #1;
        demuxInValid = 1'b0;
        m_cnt++;
        if (am) m_rr++;
        ok = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rr = 2'd0; m_cnt = 8'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        bit ok;
        exp_t e;
        outReady = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            send(6'h0A + 6'(i), 2'(i), 1'b0, ok);
            if (ok) begin
                e = sb.pop_front();
                n_checks++;
                if (get_out(e.ch) !== e.d) begin
                    n_fail++;
                    $display("FAIL rst_preload ch%0d got %h required %h", e.ch + 1, get_out(e.ch), e.d);
                end
            end
        end
        n_checks++;
        if (outValid !== 4'b1111) begin
            n_fail++;
            $display("FAIL rst_full got %b required 1111", outValid);
        end
        // Assert reset mid-cycle; outputs must clear before the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (outValid !== 4'b0000) begin n_fail++; $display("FAIL rst_valid got %b required 0000", outValid); end
        n_checks++;
        if (demuxOut1 !== 6'h00) begin n_fail++; $display("FAIL rst_out1 got %h required 00", demuxOut1); end
        n_checks++;
        if (demuxOut2 !== 6'h00) begin n_fail++; $display("FAIL rst_out2 got %h required 00", demuxOut2); end
        n_checks++;
        if (demuxOut3 !== 6'h00) begin n_fail++; $display("FAIL rst_out3 got %h required 00", demuxOut3); end
        n_checks++;
        if (demuxOut4 !== 6'h00) begin n_fail++; $display("FAIL rst_out4 got %h required 00", demuxOut4); end
        n_checks++;
        if (rrPtr !== 2'd0) begin n_fail++; $display("FAIL rst_rrptr got %0d required 0", rrPtr); end
        n_checks++;
        if (wordCount !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d required 0", wordCount); end
        @(negedge clk);
        rst = 1'b0;
        m_rr = 2'd0; m_cnt = 8'd0;
        sb.delete();
    endtask

    task automatic test_manual();
        bit ok;
        exp_t e;
        outReady = 4'b1111;
        send(6'h15, 2'b10, 1'b0, ok);
        if (ok) begin
            e = sb.pop_front();
            n_checks++;
            if (demuxOut3 !== e.d || e.ch !== 2'd2) begin
                n_fail++;
                $display("FAIL manual_data got %h required %h", demuxOut3, e.d);
            end
        end
        n_checks++;
        if (outValid !== 4'b0100) begin n_fail++; $display("FAIL manual_valid got %b required 0100", outValid); end
        n_checks++;
        if (wordCount !== 8'd1) begin n_fail++; $display("FAIL manual_count got %0d required 1", wordCount); end
    endtask

    task automatic test_round_robin();
        bit ok;
        exp_t e;
        apply_reset();
        outReady = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            send(6'(i), 2'b00, 1'b1, ok);
            if (ok) begin
                e = sb.pop_front();
                n_checks++;
                if (get_out(e.ch) !== e.d || outValid[e.ch] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_word%0d ch%0d got %h/%b required %h/1", i, e.ch + 1,
                             get_out(e.ch), outValid[e.ch], e.d);
                end
            end
        end
        n_checks++;
        if (rrPtr !== 2'd1) begin n_fail++; $display("FAIL rr_ptr got %0d required 1", rrPtr); end
        n_checks++;
        if (wordCount !== 8'd5) begin n_fail++; $display("FAIL rr_count got %0d required 5", wordCount); end
        // Manual word in between: pointer must be retained.
        send(6'h11, 2'b11, 1'b0, ok);
        if (ok) begin
            e = sb.pop_front();
            n_checks++;
            if (demuxOut4 !== e.d) begin n_fail++; $display("FAIL rr_manual got %h required %h", demuxOut4, e.d); end
        end
        n_checks++;
        if (rrPtr !== 2'd1) begin n_fail++; $display("FAIL rr_retain got %0d required 1", rrPtr); end
        send(6'h22, 2'b11, 1'b1, ok);
        if (ok) begin
            e = sb.pop_front();
            n_checks++;
            if (demuxOut2 !== e.d || e.ch !== 2'd1) begin
                n_fail++;
                $display("FAIL rr_resume got %h required %h", demuxOut2, e.d);
            end
        end
        n_checks++;
        if (rrPtr !== 2'd2) begin n_fail++; $display("FAIL rr_ptr2 got %0d required 2", rrPtr); end
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_t e;
        apply_reset();
        outReady = 4'b0000;
        send(6'h2A, 2'b01, 1'b0, ok);
        if (ok) begin
            e = sb.pop_front();
            n_checks++;
            if (demuxOut2 !== e.d) begin n_fail++; $display("FAIL bp_load got %h required %h", demuxOut2, e.d); end
        end
        demuxIn = 6'h3F; DemuxOpt = 2'b01; autoMode = 1'b0; demuxInValid = 1'b1;
        #1;
        n_checks++;
        if (demuxInReady !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b required 0", demuxInReady); end
        @(posedge clk); #1;
        n_checks++;
        if (demuxOut2 !== 6'h2A || outValid !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_hold got %h/%b required 2a/0010", demuxOut2, outValid);
        end
        // Consumer drains: the stalled word is taken in the same cycle.
        outReady = 4'b0010;
        #1;
        n_checks++;
        if (demuxInReady !== 1'b1) begin n_fail++; $display("FAIL bp_pass_ready got %b required 1", demuxInReady); end
        sb.push_back('{ch: 2'd1, d: 6'h3F});
        @(posedge clk); #1;
        demuxInValid = 1'b0;
        m_cnt++;
        e = sb.pop_front();
        n_checks++;
        if (demuxOut2 !== e.d || outValid !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_reload got %h/%b required %h/0010", demuxOut2, outValid, e.d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (outValid !== 4'b0000 || demuxOut2 !== 6'h3F) begin
            n_fail++;
            $display("FAIL bp_drain got %b/%h required 0000/3f", outValid, demuxOut2);
        end
        n_checks++;
        if (wordCount !== m_cnt) begin n_fail++; $display("FAIL bp_count got %0d required %0d", wordCount, m_cnt); end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        exp_t e;
        int bad = 0;
        apply_reset();
        outReady = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            send(6'($urandom_range(0, 63)), 2'b00, 1'b1, ok);
            if (ok) begin
                e = sb.pop_front();
                n_checks++;
                if (get_out(e.ch) !== e.d) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL wrap_word%0d ch%0d got %h required %h", i, e.ch + 1, get_out(e.ch), e.d);
                    bad++;
                end
            end
        end
        n_checks++;
        if (wordCount !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %0d required 0", wordCount); end
        send(6'h07, 2'b00, 1'b1, ok);
        if (ok) void'(sb.pop_front());
        n_checks++;
        if (wordCount !== 8'd1) begin n_fail++; $display("FAIL wrap_one got %0d required 1", wordCount); end
        n_checks++;
        if (rrPtr !== m_rr) begin n_fail++; $display("FAIL wrap_rrptr got %0d required %0d", rrPtr, m_rr); end
    endtask

    task automatic test_concurrency();
        bit ok;
        exp_t e;
        apply_reset();
        outReady = 4'b0000;
        send(6'h31, 2'b00, 1'b0, ok);
        if (ok) void'(sb.pop_front());
        n_checks++;
        if (outValid !== 4'b0001) begin n_fail++; $display("FAIL conc_pre got %b required 0001", outValid); end
        outReady = 4'b0001;
        send(6'h1C, 2'b11, 1'b0, ok);
        if (ok) begin
            e = sb.pop_front();
            n_checks++;
            if (demuxOut4 !== e.d) begin n_fail++; $display("FAIL conc_data got %h required %h", demuxOut4, e.d); end
        end
        n_checks++;
        if (outValid !== 4'b1000) begin n_fail++; $display("FAIL conc_valid got %b required 1000", outValid); end
        n_checks++;
        if (demuxOut1 !== 6'h31) begin n_fail++; $display("FAIL conc_hold got %h required 31", demuxOut1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        demuxIn = '0; demuxInValid = 1'b0; DemuxOpt = '0; autoMode = 1'b0; outReady = '0;
        m_rr = 2'd0; m_cnt = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_manual();
        test_round_robin();
        test_backpressure();
        test_counter_wrap();
        test_concurrency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
